hack_alu_pipe: RTL and testbench

HACK_ALU_PIPE -- requirements
Module: hack_alu_pipe

---
 rtl/hack_alu_pkg.sv | 33 +++
 rtl/hack_alu_operand.sv | 29 ++
 rtl/hack_alu_pipe.sv | 153 +++++++++++++++
 tb/tb_hack_alu_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hack_alu_pkg.sv
// Shared types and constants for the pipelined Hack ALU.
// Control word layout and the 18 standard Hack comp codes.
package hack_alu_pkg;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } hack_ctrl_t;

    localparam logic [5:0] C_ZERO      = 6'b101010;
    localparam logic [5:0] C_ONE       = 6'b111111;
    localparam logic [5:0] C_MINUS_1   = 6'b111010;
    localparam logic [5:0] C_X         = 6'b001100;
    localparam logic [5:0] C_Y         = 6'b110000;
    localparam logic [5:0] C_NOT_X     = 6'b001101;
    localparam logic [5:0] C_NOT_Y     = 6'b110001;
    localparam logic [5:0] C_NEG_X     = 6'b001111;
    localparam logic [5:0] C_NEG_Y     = 6'b110011;
    localparam logic [5:0] C_X_PLUS_1  = 6'b011111;
    localparam logic [5:0] C_Y_PLUS_1  = 6'b110111;
    localparam logic [5:0] C_X_MINUS_1 = 6'b001110;
    localparam logic [5:0] C_Y_MINUS_1 = 6'b110010;
    localparam logic [5:0] C_X_PLUS_Y  = 6'b000010;
    localparam logic [5:0] C_X_MINUS_Y = 6'b010011;
    localparam logic [5:0] C_Y_MINUS_X = 6'b000111;
    localparam logic [5:0] C_X_AND_Y   = 6'b000000;
    localparam logic [5:0] C_X_OR_Y    = 6'b010101;

endpackage

// File: rtl/hack_alu_operand.sv
// Operand conditioning for one Hack ALU input: optional zeroing, then optional inversion.
module hack_alu_operand #(
    parameter int W = 16
) (
    input  logic [W-1:0] data,
    input  logic         zero,
    input  logic         neg,
    output logic [W-1:0] cond_data
);

    logic [W-1:0] zeroed_s;

    // Zero first, then invert, as in the Hack ALU definition.
    always_comb begin
        zeroed_s  = '0;
        cond_data = '0;
        if (zero) begin
            zeroed_s = '0;
        end else begin
            zeroed_s = data;
        end
        if (neg) begin
            cond_data = ~zeroed_s;
        end else begin
            cond_data = zeroed_s;
        end
    end

endmodule

// File: rtl/hack_alu_pipe.sv
// Two-stage valid/ready pipelined Hack ALU with a completed-operation counter.
// Define HACK_ALU_OVF_EN to add the o_carry / o_overflow outputs.
module hack_alu_pipe
    import hack_alu_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [5:0]       i_ctrl,
    input  logic [W-1:0]     inx,
    input  logic [W-1:0]     iny,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W-1:0]     out,
    output logic             o_zero,
    output logic             o_negative,
`ifdef HACK_ALU_OVF_EN
    output logic             o_carry,
    output logic             o_overflow,
`endif
    output logic [CNT_W-1:0] o_ops_done
);

`ifdef HACK_ALU_OVF_EN
    localparam int SUM_W = W + 1;
`else
    localparam int SUM_W = W;
`endif

    hack_ctrl_t       ctrl_s;
    logic [W-1:0]     x_cond_s;
    logic [W-1:0]     y_cond_s;
    logic             s2_load_s;
    logic             s1_load_s;
    logic             accept_s;
    logic             s1_valid_r;
    logic [W-1:0]     s1_x_r;
    logic [W-1:0]     s1_y_r;
    logic             s1_f_r;
    logic             s1_no_r;
    logic             s2_valid_r;
    logic [SUM_W-1:0] sum_s;
    logic [W-1:0]     pre_s;
    logic [W-1:0]     res_s;
`ifdef HACK_ALU_OVF_EN
    logic             carry_s;
    logic             ovf_s;
`endif

    assign ctrl_s  = hack_ctrl_t'(i_ctrl);
    assign o_valid = s2_valid_r;

    hack_alu_operand #(.W(W)) u_opx (
        .data      (inx),
        .zero      (ctrl_s.zx),
        .neg       (ctrl_s.nx),
        .cond_data (x_cond_s)
    );

    hack_alu_operand #(.W(W)) u_opy (
        .data      (iny),
        .zero      (ctrl_s.zy),
        .neg       (ctrl_s.ny),
        .cond_data (y_cond_s)
    );

    // Handshake: stage 2 drains or is empty, stage 1 follows; no skid buffer.
    always_comb begin
        s2_load_s = !s2_valid_r || i_ready;
        s1_load_s = !s1_valid_r || s2_load_s;
        o_ready   = i_rst_n && s1_load_s;
        accept_s  = i_valid && o_ready;
    end

    // Stage 1: capture conditioned operands and the f/no selects.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= '0;
            s1_y_r     <= '0;
            s1_f_r     <= 1'b0;
            s1_no_r    <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_x_r  <= x_cond_s;
                s1_y_r  <= y_cond_s;
                s1_f_r  <= ctrl_s.f;
                s1_no_r <= ctrl_s.no;
            end
        end
    end

    // Function select and output inversion on the stage-1 operands.
    always_comb begin
        sum_s = SUM_W'(s1_x_r) + SUM_W'(s1_y_r);
        pre_s = '0;
        res_s = '0;
        if (s1_f_r) begin
            pre_s = sum_s[W-1:0];
        end else begin
            pre_s = s1_x_r & s1_y_r;
        end
        if (s1_no_r) begin
            res_s = ~pre_s;
        end else begin
            res_s = pre_s;
        end
`ifdef HACK_ALU_OVF_EN
        carry_s = s1_f_r & sum_s[W];
        ovf_s   = s1_f_r & (s1_x_r[W-1] == s1_y_r[W-1]) & (sum_s[W-1] != s1_x_r[W-1]);
`endif
    end

    // Stage 2: result and flags, held while downstream stalls.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_valid_r <= 1'b0;
            out        <= '0;
            o_zero     <= 1'b0;
            o_negative <= 1'b0;
`ifdef HACK_ALU_OVF_EN
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
`endif
        end else if (s2_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out        <= res_s;
                o_zero     <= (res_s == '0);
                o_negative <= res_s[W-1];
`ifdef HACK_ALU_OVF_EN
                o_carry    <= carry_s;
                o_overflow <= ovf_s;
`endif
            end
        end
    end

    // Count results handed downstream; wraps naturally.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_ops_done <= '0;
        end else if (s2_valid_r && i_ready) begin
            o_ops_done <= o_ops_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hack_alu_pipe.sv
// Randomized and directed bench for hack_alu_pipe against a queue-based reference model.
module tb_hack_alu_pipe;
    import hack_alu_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, valid, ready_dn;
    logic [5:0]    ctrl;
    logic [W-1:0]  x, y;
    logic          o_ready, o_valid, o_zero, o_negative;
    logic [W-1:0]  out;
    logic [31:0]   o_ops_done;
`ifdef HACK_ALU_OVF_EN
    logic          o_carry, o_overflow;
`endif

    hack_alu_pipe #(.W(W), .CNT_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready),
        .i_ctrl(ctrl), .inx(x), .iny(y), .o_valid(o_valid), .i_ready(ready_dn),
        .out(out), .o_zero(o_zero), .o_negative(o_negative),
`ifdef HACK_ALU_OVF_EN
        .o_carry(o_carry), .o_overflow(o_overflow),
`endif
        .o_ops_done(o_ops_done)
    );

    logic          v32;
    logic [31:0]   x32, y32, out32, done32;
    logic          rdy32, valid32, zero32, neg32;
`ifdef HACK_ALU_OVF_EN
    logic          carry32, ovf32;
`endif

    hack_alu_pipe #(.W(32), .CNT_W(32)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v32), .o_ready(rdy32),
        .i_ctrl(C_X_PLUS_Y), .inx(x32), .iny(y32), .o_valid(valid32), .i_ready(1'b1),
        .out(out32), .o_zero(zero32), .o_negative(neg32),
`ifdef HACK_ALU_OVF_EN
        .o_carry(carry32), .o_overflow(ovf32),
`endif
        .o_ops_done(done32)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] r;
        logic         carry;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int unsigned done_cnt = 0;

    function automatic exp_t ref_op(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t         e;
        logic [W-1:0] xv, yv, res;
        longint       s, ss;
        xv = c[5] ? '0 : a;
        if (c[4]) xv = ~xv;
        yv = c[3] ? '0 : b;
        if (c[2]) yv = ~yv;
        s   = longint'(xv) + longint'(yv);
        ss  = longint'($signed(xv)) + longint'($signed(yv));
        res = c[1] ? W'(s) : (xv & yv);
        if (c[0]) res = ~res;
        e.r     = res;
        e.carry = c[1] && (s >= (longint'(1) << W));
        e.ovf   = c[1] && ((ss > (longint'(1) << (W - 1)) - 1) || (ss < -(longint'(1) << (W - 1))));
        e.acc   = acc;
        return e;
    endfunction

    task automatic cycle(input logic r, input logic v, input logic rd, input logic [5:0] c,
                         input logic [W-1:0] a, input logic [W-1:0] b, output logic took);
        logic exp_valid;
        rst_n = r; valid = v; ready_dn = rd; ctrl = c; x = a; y = b;
        took = 1'b0;
        @(negedge clk);
        if (!r) begin
            check_eq("ready_in_reset", o_ready, 0);
        end else begin
            exp_valid = (q.size() > 0) && ((cyc - q[0].acc) >= 2);
            check_eq("ready", o_ready, (q.size() < 2) || rd);
            check_eq("valid", o_valid, exp_valid);
            check_eq("ops_done", o_ops_done, done_cnt);
            if (exp_valid) begin
                check_eq("out", out, q[0].r);
                check_eq("zero", o_zero, q[0].r == '0);
                check_eq("negative", o_negative, q[0].r[W-1]);
`ifdef HACK_ALU_OVF_EN
                check_eq("carry", o_carry, q[0].carry);
                check_eq("overflow", o_overflow, q[0].ovf);
`endif
                if (rd) begin
                    void'(q.pop_front());
                    done_cnt++;
                end
            end
            if (v && o_ready) begin
                q.push_back(ref_op(c, a, b, cyc));
                took = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!r) begin
            q.delete();
            done_cnt = 0;
        end
    endtask

    logic [5:0] codes [18] = '{C_ZERO, C_ONE, C_MINUS_1, C_X, C_Y, C_NOT_X, C_NOT_Y, C_NEG_X, C_NEG_Y,
                               C_X_PLUS_1, C_Y_PLUS_1, C_X_MINUS_1, C_Y_MINUS_1, C_X_PLUS_Y,
                               C_X_MINUS_Y, C_Y_MINUS_X, C_X_AND_Y, C_X_OR_Y};

    logic [5:0]   bc [3] = '{C_X_PLUS_Y, C_X_MINUS_Y, C_X_OR_Y};
    logic [W-1:0] bx [3] = '{16'd100, 16'd7, 16'h00F0};
    logic [W-1:0] by [3] = '{16'd23, 16'd9, 16'h0F00};

    initial begin
        logic       t;
        int         idx;
        int unsigned base;
        logic [5:0] c;
        v32 = 1'b0; x32 = 32'd0; y32 = 32'd0;

        cycle(1'b0, 1'b0, 1'b1, 6'd0, '0, '0, t);
        cycle(1'b0, 1'b0, 1'b1, 6'd0, '0, '0, t);
        cycle(1'b1, 1'b0, 1'b1, 6'd0, '0, '0, t);

        // W=32 wrap to zero with 2-cycle latency
        v32 = 1'b1; x32 = 32'hFFFF_FFFF; y32 = 32'd1;
        @(negedge clk);
        check_eq("w32_ready", rdy32, 1);
        @(posedge clk); #1;
        v32 = 1'b0;
        @(negedge clk);
        check_eq("w32_valid_early", valid32, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("w32_valid", valid32, 1);
        check_eq("w32_out", out32, 32'd0);
        check_eq("w32_zero", zero32, 1);
        @(posedge clk); #1;

        // Directed single operations
        cycle(1'b1, 1'b1, 1'b1, C_X_PLUS_Y, 16'd5, 16'd3, t);
        cycle(1'b1, 1'b0, 1'b1, 6'd0, '0, '0, t);
        check_eq("add_out", out, 16'd8);
        cycle(1'b1, 1'b0, 1'b1, 6'd0, '0, '0, t);
        check_eq("add_ops_done", o_ops_done, 32'd1);
        cycle(1'b1, 1'b1, 1'b1, C_X_MINUS_1, 16'd0, 16'd77, t);
        cycle(1'b1, 1'b1, 1'b1, C_ZERO, 16'h1234, 16'h5678, t);
`ifdef HACK_ALU_OVF_EN
        cycle(1'b1, 1'b1, 1'b1, C_X_PLUS_Y, 16'h7FFF, 16'h0001, t);
        cycle(1'b1, 1'b1, 1'b1, C_X_PLUS_Y, 16'hFFFF, 16'h0001, t);
`endif
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 6'd0, '0, '0, t);

        // Three back-to-back ops against a 4-cycle downstream stall
        base = done_cnt;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, bc[idx], bx[idx], by[idx], t);
            if (t) idx++;
        end
        check_eq("stall_accepted", idx, 2);
        for (int i = 0; i < 20 && idx < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b1, bc[idx], bx[idx], by[idx], t);
            if (t) idx++;
        end
        check_eq("burst_all_accepted", idx, 3);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 6'd0, '0, '0, t);
        check_eq("burst_done", o_ops_done, base + 3);

        // Reset with two operations in flight
        cycle(1'b1, 1'b1, 1'b0, C_X, 16'hAAAA, 16'd0, t);
        cycle(1'b1, 1'b1, 1'b0, C_Y, 16'd0, 16'h5555, t);
        cycle(1'b0, 1'b1, 1'b0, C_X, 16'h1111, 16'd0, t);
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_ops_done", o_ops_done, 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 6'd0, '0, '0, t);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            c = ($urandom_range(0, 1) == 0) ? codes[$urandom_range(0, 17)] : 6'($urandom);
            cycle(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, c,
                  W'($urandom), W'($urandom), t);
        end
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1, 6'd0, '0, '0, t);
        check_eq("drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
